// File: rtl/mem_stage_pkg.sv
// Shared types and encodings for the memory access stage and its MEM/WB register.
package mem_stage_pkg;

    localparam logic [1:0] MEM_NONE  = 2'b00;
    localparam logic [1:0] MEM_WRITE = 2'b01;
    localparam logic [1:0] MEM_READ  = 2'b10;
    localparam logic [1:0] MEM_BAD   = 2'b11;

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    typedef struct packed {
        logic        wb;
        logic        memtoreg;
        logic [31:0] alures;
        logic [31:0] memdata;
        logic [4:0]  rd_addr;
    } memwb_t;

    localparam int MEMWB_W = $bits(memwb_t);

    // A single read or write to a word-aligned address is the only access that reaches memory.
    function automatic logic access_ok(input logic [1:0] mem, input logic [1:0] addr_lo);
        return (mem == MEM_READ || mem == MEM_WRITE) && (addr_lo == 2'b00);
    endfunction

endpackage

// File: rtl/memwb_reg.sv
// MEM/WB pipeline register; a bubble clears only the control bits and keeps the data fields.
module memwb_reg
    import mem_stage_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               bubble,
    input  logic [MEMWB_W-1:0] d,
    output logic [MEMWB_W-1:0] q
);

    memwb_t cur;

    // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            cur <= '0;
        end else if (load) begin
            if (bubble) begin
                cur.wb       <= 1'b0;
                cur.memtoreg <= 1'b0;
            end else begin
                cur <= memwb_t'(d);
            end
        end
    end

    assign q = cur;

endmodule

// File: rtl/mem_access_stage.sv
// Memory-stage controller: issues req/ack data-memory transactions, stalls upstream while one is
// outstanding, and loads MEM/WB; misaligned, conflicting and timed-out accesses raise a sticky error.
module mem_access_stage
    import mem_stage_pkg::*;
#(
    parameter int MAX_WAIT = 15
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        WB_i,
    input  logic [1:0]  Mem_i,
    input  logic [31:0] Memaddr_i,
    input  logic [31:0] Memdata_i,
    input  logic [31:0] ALUres_i,
    input  logic [4:0]  rd_addr_i,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i,
    output logic        stall_o,
    output logic        WB_o,
    output logic        MemtoReg_o,
    output logic [31:0] ALUres_o,
    output logic [31:0] Memdata_o,
    output logic [4:0]  rd_addr_o,
    output logic        err_o
);

    localparam logic [7:0] LAST_WAIT = 8'(MAX_WAIT - 1);

    state_t     state, next_state;
    logic [7:0] wait_cnt;
    logic       stall, wb_load, wb_bubble, start_req, end_req, set_err, cnt_inc;
    memwb_t     wb_next, wb_q;

    // NOTE: every signal driven here gets a default first so no latch is inferred.
    always_comb begin
        next_state       = state;
        stall            = 1'b0;
        wb_load          = 1'b0;
        wb_bubble        = 1'b0;
        start_req        = 1'b0;
        end_req          = 1'b0;
        set_err          = 1'b0;
        cnt_inc          = 1'b0;
        wb_next.wb       = WB_i;
        wb_next.memtoreg = 1'b0;
        wb_next.alures   = ALUres_i;
        wb_next.memdata  = wb_q.memdata;
        wb_next.rd_addr  = rd_addr_i;

        case (state)
            S_IDLE: begin
                wb_load = 1'b1;
                if (Mem_i == MEM_NONE) begin
                    wb_next.wb = WB_i;
                end else if (access_ok(Mem_i, Memaddr_i[1:0])) begin
                    stall      = 1'b1;
                    wb_bubble  = 1'b1;
                    start_req  = 1'b1;
                    next_state = S_WAIT;
                end else begin
                    wb_next.wb = 1'b0;
                    set_err    = 1'b1;
                end
            end
            S_WAIT: begin
                if (mem_ack_i) begin
                    wb_load          = 1'b1;
                    wb_next.wb       = WB_i & Mem_i[1];
                    wb_next.memtoreg = Mem_i[1];
                    if (Mem_i[1]) begin
                        wb_next.memdata = mem_rdata_i;
                    end
                    end_req    = 1'b1;
                    next_state = S_IDLE;
                end else if (wait_cnt == LAST_WAIT) begin
                    wb_load    = 1'b1;
                    wb_next.wb = 1'b0;
                    set_err    = 1'b1;
                    end_req    = 1'b1;
                    next_state = S_IDLE;
                end else begin
                    stall   = 1'b1;
                    cnt_inc = 1'b1;
                end
            end
            default: next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= S_IDLE;
            wait_cnt    <= '0;
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            err_o       <= 1'b0;
        end else begin
            state <= next_state;
            err_o <= err_o | set_err;
            if (start_req) begin
                mem_req_o   <= 1'b1;
                mem_we_o    <= Mem_i[0];
                mem_addr_o  <= Memaddr_i;
                mem_wdata_o <= Memdata_i;
                wait_cnt    <= '0;
            end else begin
                if (end_req) begin
                    mem_req_o <= 1'b0;
                end
                if (cnt_inc) begin
                    wait_cnt <= wait_cnt + 8'd1;
                end
            end
        end
    end

    assign stall_o = stall & ~rst_i;

    memwb_reg u_memwb (
        .clk    (clk_i),
        .rst    (rst_i),
        .load   (wb_load),
        .bubble (wb_bubble),
        .d      (wb_next),
        .q      (wb_q)
    );

    assign WB_o       = wb_q.wb;
    assign MemtoReg_o = wb_q.memtoreg;
    assign ALUres_o   = wb_q.alures;
    assign Memdata_o  = wb_q.memdata;
    assign rd_addr_o  = wb_q.rd_addr;

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: a transaction-level timeline model sets the expected
// outputs for every cycle and one negedge process compares them; directed cases pin literal values.
module tb_mem_access_stage;

    localparam int MAX_WAIT = 4;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        WB_i = 1'b0;
    logic [1:0]  Mem_i = 2'b00;
    logic [31:0] Memaddr_i = '0;
    logic [31:0] Memdata_i = '0;
    logic [31:0] ALUres_i = '0;
    logic [4:0]  rd_addr_i = '0;
    logic        mem_ack_i = 1'b0;
    logic [31:0] mem_rdata_i = '0;
    logic        mem_req_o, mem_we_o, stall_o, WB_o, MemtoReg_o, err_o;
    logic [31:0] mem_addr_o, mem_wdata_o, ALUres_o, Memdata_o;
    logic [4:0]  rd_addr_o;

    int checks = 0;
    int failures = 0;
    int stall_hi = 0;
    int req_hi = 0;
    bit check_en = 1'b0;

    // Expected visible outputs for the current cycle.
    logic        exp_stall, exp_req, exp_we, exp_err;
    logic [31:0] exp_addr, exp_wdata;
    logic        mw_wb, mw_mtr;
    logic [31:0] mw_alu, mw_mem;
    logic [4:0]  mw_rd;

    mem_access_stage #(.MAX_WAIT(MAX_WAIT)) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .WB_i        (WB_i),
        .Mem_i       (Mem_i),
        .Memaddr_i   (Memaddr_i),
        .Memdata_i   (Memdata_i),
        .ALUres_i    (ALUres_i),
        .rd_addr_i   (rd_addr_i),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_ack_i   (mem_ack_i),
        .mem_rdata_i (mem_rdata_i),
        .stall_o     (stall_o),
        .WB_o        (WB_o),
        .MemtoReg_o  (MemtoReg_o),
        .ALUres_o    (ALUres_o),
        .Memdata_o   (Memdata_o),
        .rd_addr_o   (rd_addr_o),
        .err_o       (err_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (check_en) begin
            check("stall_o", stall_o, exp_stall);
            check("mem_req_o", mem_req_o, exp_req);
            if (exp_req) begin
                check("mem_we_o", mem_we_o, exp_we);
                check("mem_addr_o", mem_addr_o, exp_addr);
                check("mem_wdata_o", mem_wdata_o, exp_wdata);
            end
            check("WB_o", WB_o, mw_wb);
            check("MemtoReg_o", MemtoReg_o, mw_mtr);
            check("ALUres_o", ALUres_o, mw_alu);
            check("Memdata_o", Memdata_o, mw_mem);
            check("rd_addr_o", rd_addr_o, mw_rd);
            check("err_o", err_o, exp_err);
            if (stall_o) stall_hi++;
            if (mem_req_o) req_hi++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic zero_model();
        exp_stall = 1'b0; exp_req = 1'b0; exp_we = 1'b0; exp_err = 1'b0;
        exp_addr = '0; exp_wdata = '0;
        mw_wb = 1'b0; mw_mtr = 1'b0; mw_alu = '0; mw_mem = '0; mw_rd = '0;
    endtask

    task automatic do_reset(input int n);
        rst_i = 1'b1;
        Mem_i = 2'b10;
        mem_ack_i = 1'b0;
        exp_stall = 1'b0;
        for (int i = 0; i < n; i++) begin
            tick();
            zero_model();
            check_en = 1'b1;
        end
        rst_i = 1'b0;
        Mem_i = 2'b00;
    endtask

    task automatic drive(input logic wb, input logic [1:0] mem, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] alu, input logic [4:0] rd);
        WB_i = wb; Mem_i = mem; Memaddr_i = addr; Memdata_i = wdata; ALUres_i = alu; rd_addr_i = rd;
    endtask

    // One instruction from arrival to MEM/WB load. ack_k = cycles after mem_req_o rises that the
    // ack arrives (negative: never). idle_ack pulses a stray ack in the arrival cycle.
    task automatic issue(input logic wb, input logic [1:0] mem, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] alu, input logic [4:0] rd,
                         input int ack_k, input logic [31:0] rdata, input bit idle_ack);
        bit is_read, is_write;
        is_read  = (mem == 2'b10);
        is_write = (mem == 2'b01);
        drive(wb, mem, addr, wdata, alu, rd);
        mem_ack_i = idle_ack;
        mem_rdata_i = $urandom;
        if (mem == 2'b00) begin
            exp_stall = 1'b0;
            tick();
            mem_ack_i = 1'b0;
            mw_wb = wb; mw_mtr = 1'b0; mw_alu = alu; mw_rd = rd;
        end else if (!(is_read || is_write) || addr[1:0] != 2'b00) begin
            exp_stall = 1'b0;
            tick();
            mem_ack_i = 1'b0;
            mw_wb = 1'b0; mw_mtr = 1'b0; mw_alu = alu; mw_rd = rd;
            exp_err = 1'b1;
        end else begin
            exp_stall = 1'b1;
            tick();
            mem_ack_i = 1'b0;
            exp_req = 1'b1; exp_we = is_write; exp_addr = addr; exp_wdata = wdata;
            mw_wb = 1'b0; mw_mtr = 1'b0;
            for (int w = 0; w < MAX_WAIT; w++) begin
                if (w == ack_k) begin
                    mem_ack_i = 1'b1;
                    mem_rdata_i = rdata;
                    exp_stall = 1'b0;
                    tick();
                    mem_ack_i = 1'b0;
                    exp_req = 1'b0;
                    mw_wb = wb & is_read; mw_mtr = is_read; mw_alu = alu; mw_rd = rd;
                    if (is_read) mw_mem = rdata;
                    break;
                end else if (w == MAX_WAIT - 1) begin
                    exp_stall = 1'b0;
                    tick();
                    exp_req = 1'b0;
                    exp_err = 1'b1;
                    mw_wb = 1'b0; mw_mtr = 1'b0; mw_alu = alu; mw_rd = rd;
                    break;
                end else begin
                    exp_stall = 1'b1;
                    tick();
                end
            end
        end
    endtask

    // Load abandoned by a reset asserted in the third WAIT cycle.
    task automatic issue_abort(input logic [31:0] addr);
        drive(1'b1, 2'b10, addr, 32'h0, 32'h55, 5'd9);
        exp_stall = 1'b1;
        tick();
        exp_req = 1'b1; exp_we = 1'b0; exp_addr = addr; exp_wdata = 32'h0;
        mw_wb = 1'b0; mw_mtr = 1'b0;
        tick();
        tick();
        rst_i = 1'b1;
        exp_stall = 1'b0;
        tick();
        zero_model();
        rst_i = 1'b0;
    endtask

    initial begin
        int s0, r0;
        zero_model();

        do_reset(2);
        check("reset_req", mem_req_o, 1'b0);
        check("reset_stall", stall_o, 1'b0);

        issue(1'b1, 2'b00, 32'h0, 32'h0, 32'h0000_002A, 5'd5, -1, 32'h0, 1'b0);
        check("alu_wb", WB_o, 1'b1);
        check("alu_res", ALUres_o, 32'h2A);
        check("alu_rd", rd_addr_o, 5'd5);
        check("alu_mtr", MemtoReg_o, 1'b0);

        s0 = stall_hi; r0 = req_hi;
        issue(1'b1, 2'b10, 32'h100, 32'h0, 32'h77, 5'd7, 3, 32'hDEAD_BEEF, 1'b0);
        check("load_stall_cycles", stall_hi - s0, 4);
        check("load_req_cycles", req_hi - r0, 4);
        check("load_wb", WB_o, 1'b1);
        check("load_mtr", MemtoReg_o, 1'b1);
        check("load_data", Memdata_o, 32'hDEAD_BEEF);

        s0 = stall_hi; r0 = req_hi;
        issue(1'b1, 2'b01, 32'h200, 32'h1234_5678, 32'h88, 5'd8, 0, 32'h0, 1'b0);
        check("store_stall_cycles", stall_hi - s0, 1);
        check("store_wb", WB_o, 1'b0);
        check("store_err", err_o, 1'b0);
        check("store_keeps_data", Memdata_o, 32'hDEAD_BEEF);

        r0 = req_hi;
        issue(1'b1, 2'b10, 32'h102, 32'h0, 32'h11, 5'd11, 0, 32'h0, 1'b0);
        check("misalign_wb", WB_o, 1'b0);
        issue(1'b1, 2'b11, 32'h200, 32'h0, 32'h12, 5'd12, 0, 32'h0, 1'b0);
        check("bad_wb", WB_o, 1'b0);
        issue(1'b1, 2'b00, 32'h0, 32'h0, 32'h13, 5'd13, -1, 32'h0, 1'b0);
        check("bad_req_cycles", req_hi - r0, 0);
        check("err_sticky", err_o, 1'b1);

        do_reset(2);
        r0 = req_hi;
        issue(1'b1, 2'b10, 32'h300, 32'h0, 32'h21, 5'd21, -1, 32'h0, 1'b0);
        check("timeout_req_cycles", req_hi - r0, MAX_WAIT);
        check("timeout_err", err_o, 1'b1);
        issue(1'b1, 2'b00, 32'h0, 32'h0, 32'h22, 5'd22, -1, 32'h0, 1'b1);
        check("late_ack_wb", WB_o, 1'b1);
        check("late_ack_req", mem_req_o, 1'b0);

        do_reset(2);
        issue_abort(32'h400);
        check("abort_req", mem_req_o, 1'b0);
        check("abort_err", err_o, 1'b0);
        issue(1'b1, 2'b00, 32'h0, 32'h0, 32'h23, 5'd23, -1, 32'h0, 1'b1);

        for (int n = 0; n < 300; n++) begin
            int r, k;
            logic [1:0]  mem;
            logic [31:0] addr;
            r = $urandom_range(0, 39);
            if (r == 0) begin
                do_reset($urandom_range(1, 2));
                continue;
            end
            r = $urandom_range(0, 9);
            addr = $urandom & 32'hFFFF_FFFC;
            if (r < 4) begin
                mem = 2'b00;
                addr = $urandom;
            end else if (r < 6) mem = 2'b10;
            else if (r < 8) mem = 2'b01;
            else if (r == 8) mem = 2'b11;
            else begin
                mem = $urandom_range(1, 2);
                addr = addr | 32'($urandom_range(1, 3));
            end
            k = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, MAX_WAIT + 1));
            issue(1'($urandom), mem, addr, $urandom, $urandom, 5'($urandom), k, $urandom,
                  1'($urandom_range(0, 3) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish, checks=%0d", checks);
        $fatal(1, "bench time limit reached");
    end

endmodule
